// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks a contiguous, optionally wrapping, range of register-file
// addresses through one read port. Each captured value goes out, tagged with its address,
// on a valid/ready stream. Meant to drive the r2A/r2D port while the CPU is halted.
`timescale 1ns/1ps

module reg_dump_sequencer #(
    parameter int unsigned READ_LAT = 1,  // cycles from driving RA to sampling RD, 1..3
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] FIRST_ADDR,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic [ADDR_W-1:0] RA,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [ADDR_W-1:0] OUT_ADDR,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic              DONE
);

    // Reload value for the read-latency counter; two bits cover READ_LAT up to 4.
    localparam logic [1:0] CntInit = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPresent
    } state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] ra_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    // Dump FSM; every output is a register updated here.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            last_q      <= '0;
            ra_q        <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The DONE cycle is still part of the previous dump, so START is refused.
                    if (START && !done_q) begin
                        last_q  <= LAST_ADDR;
                        ra_q    <= FIRST_ADDR;
                        cnt_q   <= CntInit;
                        busy_q  <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        out_data_q  <= RD;
                        out_addr_q  <= ra_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StPresent;
                    end
                end
                StPresent: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        if (ra_q == last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            // Natural wrap of the address width gives the 15 -> 0 step.
                            ra_q    <= ra_q + ADDR_W'(1);
                            cnt_q   <= CntInit;
                            state_q <= StWait;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign RA        = ra_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_ADDR  = out_addr_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: a READ_LAT=1 instance on a combinational
// register-file model and a READ_LAT=3 instance on a synchronous-read model.
`timescale 1ns/1ps

module tb_reg_dump_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start3;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic        out_ready;

    logic [3:0]  ra;
    logic [15:0] rd;
    logic [15:0] out_data;
    logic [3:0]  out_addr;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [3:0]  ra3;
    logic [15:0] rd3;
    logic [15:0] out_data3;
    logic [3:0]  out_addr3;
    logic        out_valid3;
    logic        busy3;
    logic        done3;

    logic [15:0] mem1 [16];
    logic [15:0] mem3 [16];

    int checks;
    int failures;

    typedef struct {
        logic [3:0] first;
        logic [3:0] last;
        int         exp_n;
        int         stall_idx;
        int         stall_cyc;
        int         restart_idx;
    } vec_t;

    vec_t vecs [5];

    reg_dump_sequencer #(.READ_LAT(1), .ADDR_W(4), .DATA_W(16)) u_dut1 (
        .CLK        (clk),
        .RESET      (rst_n),
        .START      (start),
        .FIRST_ADDR (first_addr),
        .LAST_ADDR  (last_addr),
        .RA         (ra),
        .RD         (rd),
        .OUT_DATA   (out_data),
        .OUT_ADDR   (out_addr),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .BUSY       (busy),
        .DONE       (done)
    );

    reg_dump_sequencer #(.READ_LAT(3), .ADDR_W(4), .DATA_W(16)) u_dut3 (
        .CLK        (clk),
        .RESET      (rst_n),
        .START      (start3),
        .FIRST_ADDR (first_addr),
        .LAST_ADDR  (last_addr),
        .RA         (ra3),
        .RD         (rd3),
        .OUT_DATA   (out_data3),
        .OUT_ADDR   (out_addr3),
        .OUT_VALID  (out_valid3),
        .OUT_READY  (out_ready),
        .BUSY       (busy3),
        .DONE       (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file models: combinational read for latency 1, registered read for latency 3.
    assign rd = mem1[ra];
    always @(posedge clk) rd3 <= mem3[ra3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_dump(input vec_t v);
        int          words;
        int          cyc;
        int          hs;
        int          budget;
        bit          fin;
        logic [3:0]  exp_a;
        logic [15:0] exp_d;
        @(negedge clk);
        first_addr = v.first;
        last_addr  = v.last;
        out_ready  = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = ~v.first;  // later changes must have no effect
        last_addr  = ~v.last;
        chk("busy_after_start", 32'(busy), 32'd1);
        words = 0; cyc = 0; hs = -1; fin = 1'b0; budget = 0;
        while (!fin && budget < 400) begin
            start = 1'b0;
            if (done) begin
                chk("word_count", 32'(words), 32'(v.exp_n));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("valid_at_done", 32'(out_valid), 32'd0);
                // START coinciding with DONE must be refused.
                start      = 1'b1;
                first_addr = 4'd7;
                last_addr  = 4'd7;
                fin        = 1'b1;
            end else if (out_valid) begin
                exp_a = v.first + 4'(words);
                exp_d = 16'(exp_a) * 16'd3;
                chk("word_time", 32'(cyc), 32'(hs + 2));
                chk("out_addr", 32'(out_addr), 32'(exp_a));
                chk("out_data", 32'(out_data), 32'(exp_d));
                chk("ra_word", 32'(ra), 32'(exp_a));
                if (words == v.stall_idx) begin
                    out_ready = 1'b0;
                    for (int k = 0; k < v.stall_cyc; k++) begin
                        @(negedge clk);
                        cyc++;
                        chk("stall_valid", 32'(out_valid), 32'd1);
                        chk("stall_addr", 32'(out_addr), 32'(exp_a));
                        chk("stall_data", 32'(out_data), 32'(exp_d));
                        chk("stall_ra", 32'(ra), 32'(exp_a));
                    end
                    out_ready = 1'b1;
                end
                if (words == v.restart_idx) begin
                    start      = 1'b1;
                    first_addr = 4'd9;
                    last_addr  = 4'd9;
                end
                hs = cyc;
                words++;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
                budget++;
            end
        end
        if (!fin) chk("dump_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("start_with_done_ignored", 32'(busy), 32'd0);
        chk("single_done", 32'(done), 32'd0);
    endtask

    initial begin
        int words;
        int cyc;
        int hs;
        int budget;
        bit fin;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start3     = 1'b0;
        first_addr = 4'd0;
        last_addr  = 4'd0;
        out_ready  = 1'b1;
        for (int n = 0; n < 16; n++) begin
            mem1[n] = 16'(n * 3);
            mem3[n] = 16'(16'h1000 + n * 16'h0101);
        end

        //                first  last  n   stall  cyc  restart
        vecs[0] = '{4'd0,  4'd15, 16, -1, 0, -1};
        vecs[1] = '{4'd14, 4'd1,  4,  -1, 0, -1};
        vecs[2] = '{4'd5,  4'd5,  1,  -1, 0, -1};
        vecs[3] = '{4'd0,  4'd5,  6,  2,  7, -1};
        vecs[4] = '{4'd3,  4'd10, 8,  -1, 0, 4};

        repeat (2) @(negedge clk);
        chk("rst_ra", 32'(ra), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_dump(vecs[i]);

        // Asynchronous reset while word 4 is presented.
        @(negedge clk);
        first_addr = 4'd0;
        last_addr  = 4'd15;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (!(out_valid && out_addr == 4'd4) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_word4", 32'(out_addr), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ra", 32'(ra), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_addr", 32'(out_addr), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run_dump('{4'd2, 4'd3, 2, -1, 0, -1});

        // READ_LAT=3 instance: first word 4 edges after START, then one every 4 cycles.
        @(negedge clk);
        first_addr = 4'd0;
        last_addr  = 4'd3;
        out_ready  = 1'b1;
        start3     = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("lat3_busy", 32'(busy3), 32'd1);
        words = 0; cyc = 0; hs = -1; fin = 1'b0; budget = 0;
        while (!fin && budget < 100) begin
            if (done3) begin
                chk("lat3_count", 32'(words), 32'd4);
                chk("lat3_busy_done", 32'(busy3), 32'd0);
                fin = 1'b1;
            end else if (out_valid3) begin
                chk("lat3_time", 32'(cyc), 32'(hs + 4));
                chk("lat3_addr", 32'(out_addr3), 32'(words));
                chk("lat3_data", 32'(out_data3), 32'(mem3[words]));
                hs = cyc;
                words++;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
                budget++;
            end
        end
        if (!fin) chk("lat3_timeout", 32'd0, 32'd1);
        chk("lat1_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
